// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: registered ALU control decode (ALUOp/funct -> ALU op code) with a
// counter-driven MULT/DIV sequencer that stalls the front end and pulses the
// HI/LO write enable when the multi-cycle op completes.
// Latency: 1 cycle from accept to ALUCtrl_o; MULT/DIV hold stall_o for N cycles.
// Backpressure: stall_o high while busy; valid_i is ignored until stall_o drops.
// Ports:
//   clk_i, rst_i (sync, active-high)      clock / reset
//   valid_i, ALUOp_i[2:0], funct_i[5:0]   decode slot from the main decoder
//   flush_i                               squash registered op, abort MULT/DIV
//   ALUCtrl_o, ctrl_valid_o, illegal_o    registered ALU op code and qualifiers
//   stall_o, hilo_we_o                    sequencer busy / one-cycle HI/LO write
// Optional feature: define ALU_CTRL_DIV_EN to decode funct 26 as DIV (code 9),
// sequenced for DIV_CYCLES; otherwise funct 26 is illegal and DIV_CYCLES unused
// beyond sizing the counter.
module alu_ctrl_mc #(
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              ctrl_valid_o,
  output logic              illegal_o,
  output logic              stall_o,
  output logic              hilo_we_o
);

  // Counter only ever holds N-1, so log2 of the larger cycle count suffices.
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               vld_q, vld_d;
  logic               ill_q, ill_d;

  logic [3:0]         dec_code;
  logic               dec_ill;
  logic               dec_mult;
  logic               dec_div;
  logic               accept;

  // Combinational decode of the current decode slot.
  always_comb begin
    dec_code = 4'd0;
    dec_ill  = 1'b0;
    dec_mult = 1'b0;
    dec_div  = 1'b0;
    case (ALUOp_i)
      3'b000: dec_code = 4'd2;   // lw/sw -> add
      3'b001: dec_code = 4'd6;   // beq   -> sub
      3'b011: dec_code = 4'd2;   // addi  -> add
      3'b100: dec_code = 4'd1;   // ori   -> or
      3'b111: dec_code = 4'd7;   // slti  -> slt
      3'b010: begin
        case (funct_i)
          6'd32: dec_code = 4'd2;
          6'd34: dec_code = 4'd6;
          6'd36: dec_code = 4'd0;
          6'd37: dec_code = 4'd1;
          6'd39: dec_code = 4'd12;
          6'd42: dec_code = 4'd7;
          6'd24: begin
            dec_code = 4'd8;
            dec_mult = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          6'd26: begin
            dec_code = 4'd9;
            dec_div  = 1'b1;
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;   // 101, 110
    endcase
  end

  assign stall_o = (state_q == BUSY);
  assign accept  = valid_i & ~stall_o & ~flush_i;

  // Completion pulse is suppressed combinationally if the final busy cycle is
  // flushed or reset, so an aborted op never writes HI/LO.
  assign hilo_we_o = stall_o & (cnt_q == '0) & ~flush_i & ~rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    vld_d   = vld_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ctrl_d = dec_ill ? {CTRL_W{1'b1}} : CTRL_W'(dec_code);
          vld_d  = 1'b1;
          ill_d  = dec_ill;
          if (dec_mult) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MULT_CYCLES - 1);
          end
`ifdef ALU_CTRL_DIV_EN
          if (dec_div) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
          end
`endif
        end else begin
          // Bubble or flush: op code holds, qualifiers drop.
          vld_d = 1'b0;
          ill_d = 1'b0;
        end
      end
      BUSY: begin
        // The MULT/DIV op stays presented on ALUCtrl_o while busy.
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          vld_d   = 1'b0;
          ill_d   = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
    end
  end

  // dec_div is only consumed when the DIV path is compiled in.
  logic unused_div;
  assign unused_div = dec_div;

  assign ALUCtrl_o    = ctrl_q;
  assign ctrl_valid_o = vld_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
module tb_alu_ctrl_mc;

  localparam int MC = 4;
  localparam int DC = 8;

  logic       clk;
  logic       rst, valid, flush;
  logic [2:0] aluop;
  logic [5:0] funct;

  logic [3:0] alu_o;
  logic       vld_o, ill_o, st_o, hi_o;
  logic [3:0] alu1;
  logic       vld1, ill1, st1, hi1;

  int checks = 0;
  int failures = 0;

  alu_ctrl_mc #(.CTRL_W(4), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(aluop), .funct_i(funct),
    .flush_i(flush), .ALUCtrl_o(alu_o), .ctrl_valid_o(vld_o), .illegal_o(ill_o),
    .stall_o(st_o), .hilo_we_o(hi_o));

  // Single-cycle MULT/DIV instance for the N = 1 boundary.
  alu_ctrl_mc #(.CTRL_W(4), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(aluop), .funct_i(funct),
    .flush_i(flush), .ALUCtrl_o(alu1), .ctrl_valid_o(vld1), .illegal_o(ill1),
    .stall_o(st1), .hilo_we_o(hi1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_ctrl;
  logic       m_vld, m_ill;
  int         m_rem;   // stall cycles still to come, including the current one

  function automatic void ref_dec(input logic [2:0] op, input logic [5:0] fn,
                                  output logic [3:0] c, output logic il, output int n);
    il = 1'b0; n = 0; c = 4'hF;
    case (op)
      3'd0: c = 4'd2;
      3'd1: c = 4'd6;
      3'd3: c = 4'd2;
      3'd4: c = 4'd1;
      3'd7: c = 4'd7;
      3'd2: begin
        case (fn)
          6'd32: c = 4'd2;
          6'd34: c = 4'd6;
          6'd36: c = 4'd0;
          6'd37: c = 4'd1;
          6'd39: c = 4'd12;
          6'd42: c = 4'd7;
          6'd24: begin c = 4'd8; n = MC; end
`ifdef ALU_CTRL_DIV_EN
          6'd26: begin c = 4'd9; n = DC; end
`endif
          default: il = 1'b1;
        endcase
      end
      default: il = 1'b1;
    endcase
    if (il) c = 4'hF;
  endfunction

  task automatic model_edge();
    logic [3:0] c;
    logic       il;
    int         n;
    if (rst) begin
      m_ctrl = 4'd0; m_vld = 1'b0; m_ill = 1'b0; m_rem = 0;
    end else if (m_rem > 0) begin
      if (flush) begin
        m_rem = 0; m_vld = 1'b0; m_ill = 1'b0;
      end else begin
        m_rem = m_rem - 1;
      end
    end else if (valid && !flush) begin
      ref_dec(aluop, funct, c, il, n);
      m_ctrl = c; m_vld = 1'b1; m_ill = il; m_rem = n;
    end else begin
      m_vld = 1'b0; m_ill = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] c,
                     input logic v, input logic il, input logic s, input logic h);
    checks++;
    if (alu_o !== c || vld_o !== v || ill_o !== il || st_o !== s || hi_o !== h) begin
      failures++;
      $display("FAIL %s[%0d]: got ctrl=%h vld=%b ill=%b stall=%b hilo=%b, want ctrl=%h vld=%b ill=%b stall=%b hilo=%b",
               name, idx, alu_o, vld_o, ill_o, st_o, hi_o, c, v, il, s, h);
    end
  endtask

  task automatic chk1(input string name, input logic [3:0] c, input logic v,
                      input logic s, input logic h);
    checks++;
    if (alu1 !== c || vld1 !== v || st1 !== s || hi1 !== h) begin
      failures++;
      $display("FAIL %s: got ctrl=%h vld=%b stall=%b hilo=%b, want ctrl=%h vld=%b stall=%b hilo=%b",
               name, alu1, vld1, st1, hi1, c, v, s, h);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, v;
    logic [2:0] op;
    logic [5:0] fn;
    logic       fl;
    logic [3:0] ctrl;
    logic       vld, ill, stall, hilo;
  } vec_t;

  vec_t tbl[$];

  // Expected values are the outputs seen during the cycle the inputs are applied.
  task automatic add(input logic r, input logic v, input logic [2:0] op, input logic [5:0] fn,
                     input logic fl, input logic [3:0] c, input logic vd, input logic il,
                     input logic st, input logic hi);
    vec_t e;
    e.rst = r; e.v = v; e.op = op; e.fn = fn; e.fl = fl;
    e.ctrl = c; e.vld = vd; e.ill = il; e.stall = st; e.hilo = hi;
    tbl.push_back(e);
  endtask

  logic [3:0] c_last;
  logic [5:0] fsel [10];

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; aluop = 3'd0; funct = 6'd0;
    m_ctrl = 4'd0; m_vld = 1'b0; m_ill = 1'b0; m_rem = 0;

    // Reset, then R-format stream with no bubbles.
    add(1,0,3'd0,6'd0, 0, 4'd0, 0,0,0,0);
    add(0,1,3'd2,6'd32,0, 4'd0, 0,0,0,0);
    add(0,1,3'd2,6'd34,0, 4'd2, 1,0,0,0);
    add(0,1,3'd2,6'd36,0, 4'd6, 1,0,0,0);
    add(0,1,3'd2,6'd37,0, 4'd0, 1,0,0,0);
    add(0,1,3'd2,6'd39,0, 4'd1, 1,0,0,0);
    add(0,1,3'd2,6'd42,0, 4'd12,1,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd7, 1,0,0,0);
    // MULT accepted at "edge 0"; lw presented while busy, accepted at edge 5.
    add(0,1,3'd2,6'd24,0, 4'd7, 0,0,0,0);
    add(0,1,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,1,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,1,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,1,3'd0,6'd0, 0, 4'd8, 1,0,1,1);
    add(0,1,3'd0,6'd0, 0, 4'd8, 1,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd2, 1,0,0,0);
    add(0,1,3'd2,6'd26,0, 4'd2, 0,0,0,0);
`ifdef ALU_CTRL_DIV_EN
    // DIV flushed in busy cycle 3.
    add(0,0,3'd0,6'd0, 0, 4'd9, 1,0,1,0);
    add(0,0,3'd0,6'd0, 0, 4'd9, 1,0,1,0);
    add(0,0,3'd0,6'd0, 1, 4'd9, 1,0,1,0);
    add(0,0,3'd0,6'd0, 0, 4'd9, 0,0,0,0);
    // Full DIV: 8 stall cycles, pulse in the 8th.
    add(0,1,3'd2,6'd26,0, 4'd9, 0,0,0,0);
    for (int i = 1; i <= 7; i++) add(0,0,3'd0,6'd0,0, 4'd9,1,0,1,0);
    add(0,0,3'd0,6'd0, 0, 4'd9, 1,0,1,1);
    add(0,0,3'd0,6'd0, 0, 4'd9, 1,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd9, 0,0,0,0);
    c_last = 4'd9;
`else
    // funct 26 is illegal without the DIV path: no stall.
    add(0,0,3'd0,6'd0, 0, 4'hF, 1,1,0,0);
    add(0,0,3'd0,6'd0, 0, 4'hF, 0,0,0,0);
    c_last = 4'hF;
`endif
    // MULT reset in busy cycle 2, then illegal ALUOp 101.
    add(0,1,3'd2,6'd24,0, c_last,0,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(1,0,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,1,3'd5,6'd0, 0, 4'd0, 0,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'hF, 1,1,0,0);
    // Flush outside busy beats a simultaneous valid.
    add(0,1,3'd4,6'd0, 1, 4'hF, 0,0,0,0);
    add(0,1,3'd7,6'd0, 0, 4'hF, 0,0,0,0);
    add(0,1,3'd1,6'd0, 0, 4'd7, 1,0,0,0);
    add(0,1,3'd3,6'd0, 0, 4'd6, 1,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd2, 1,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd2, 0,0,0,0);
    // Flush in the final busy cycle suppresses the HI/LO pulse.
    add(0,1,3'd2,6'd24,0, 4'd2, 0,0,0,0);
    add(0,0,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,0,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,0,3'd0,6'd0, 0, 4'd8, 1,0,1,0);
    add(0,0,3'd0,6'd0, 1, 4'd8, 1,0,1,0);
    add(0,0,3'd0,6'd0, 0, 4'd8, 0,0,0,0);
    // Unknown R-format funct and ALUOp 110 are illegal.
    add(0,1,3'd2,6'd0, 0, 4'd8, 0,0,0,0);
    add(0,1,3'd6,6'd0, 0, 4'hF, 1,1,0,0);
    add(0,0,3'd0,6'd0, 0, 4'hF, 1,1,0,0);
    add(0,0,3'd0,6'd0, 0, 4'hF, 0,0,0,0);

    tick();
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; valid = tbl[i].v; aluop = tbl[i].op;
      funct = tbl[i].fn; flush = tbl[i].fl;
      @(negedge clk);
      chk("tbl", i, tbl[i].ctrl, tbl[i].vld, tbl[i].ill, tbl[i].stall, tbl[i].hilo);
      tick();
    end

    // Randomized stimulus against the reference model.
    fsel[0] = 6'd32; fsel[1] = 6'd34; fsel[2] = 6'd36; fsel[3] = 6'd37; fsel[4] = 6'd39;
    fsel[5] = 6'd42; fsel[6] = 6'd24; fsel[7] = 6'd26; fsel[8] = 6'd0;  fsel[9] = 6'd63;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      valid = ($urandom_range(0, 3) != 0);
      aluop = 3'($urandom_range(0, 7));
      if (aluop == 3'd5 || aluop == 3'd6 || $urandom_range(0, 2) != 0) aluop = 3'd2;
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                          : fsel[$urandom_range(0, 9)];
      @(negedge clk);
      chk("rand", i, m_ctrl, m_vld, m_ill, (m_rem > 0),
          (m_rem == 1) && !flush && !rst);
      tick();
    end

    // N = 1 boundary on the single-cycle instance.
    rst = 1'b1; valid = 1'b0; flush = 1'b0; aluop = 3'd0; funct = 6'd0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("n1_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    valid = 1'b1; aluop = 3'd2; funct = 6'd24;
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk1("n1_mult_busy", 4'd8, 1'b1, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk1("n1_mult_done", 4'd8, 1'b1, 1'b0, 1'b0);
`ifdef ALU_CTRL_DIV_EN
    valid = 1'b1; aluop = 3'd2; funct = 6'd26;
    tick();
    valid = 1'b0;
    @(negedge clk);
    chk1("n1_div_busy", 4'd9, 1'b1, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk1("n1_div_done", 4'd9, 1'b1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
